// File: rtl/filter_test_sequencer.sv
// filter_test_sequencer: drives a filter-under-test through a sweep of
// generator delays. Each step settles, fires one test_rate trigger, tracks
// the signed peak of filter_data over a measurement window and reports it
// through a valid/ready result port.
// Optional feature: define FILTER_SEQ_TIMEOUT_EN to give up on a stalled
// result consumer after TIMEOUT_CYCLES and flag it on the sticky err output.
module filter_test_sequencer #(
   parameter int SETTLE_CYCLES    = 64,
   parameter int WINDOW_CYCLES    = 256,
   parameter int TIMEOUT_CYCLES   = 1024,
   parameter int SIZE_DELAY       = 8,
   parameter int SIZE_FILTER_DATA = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               abort,
   input  logic        [SIZE_DELAY-1:0]       delay_start,
   input  logic        [SIZE_DELAY-1:0]       delay_step,
   input  logic        [7:0]                  n_steps,
   input  logic                               overlay_en,
   input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
   input  logic                               res_ready,
   output logic                               test_rate,
   output logic                               test_overlay,
   output logic        [SIZE_DELAY-1:0]       test_delay,
   output logic                               busy,
   output logic                               done,
   output logic                               res_valid,
   output logic        [7:0]                  res_step,
   output logic        [SIZE_DELAY-1:0]       res_delay,
   output logic signed [SIZE_FILTER_DATA-1:0] res_peak,
   output logic        [15:0]                 res_peak_time,
   output logic                               err
);

   localparam int CMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);

   // Degenerate timings would make the phase counters wrap forever.
   if (SETTLE_CYCLES < 1 || WINDOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("filter_test_sequencer: cycle parameters must be >= 1");
   end

   typedef enum logic [2:0] {IDLE, SETTLE, WINDOW, REPORT, FIN} state_t;

   state_t                             state;
   logic        [CW-1:0]               cnt;
   logic        [7:0]                  step;
   logic        [7:0]                  n_steps_q;
   logic        [SIZE_DELAY-1:0]       delay_step_q;
   logic                               overlay_q;
   logic signed [SIZE_FILTER_DATA-1:0] peak;
   logic        [15:0]                 peak_time;
   logic signed [SIZE_FILTER_DATA-1:0] pk_nxt;
   logic        [15:0]                 pt_nxt;
   logic                               to_hit;
   logic                               adv;
   logic        [1:0]                  rst_sync;
   logic                               rst_n;

   // Reset asserts immediately, releases two clk edges after reset rises.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // Peak tracker: first window sample seeds, later ones win only if strictly greater.
   always_comb begin
      pk_nxt = peak;
      pt_nxt = peak_time;
      if (cnt == '0) begin
         pk_nxt = filter_data;
         pt_nxt = 16'd0;
      end else if (filter_data > peak) begin
         pk_nxt = filter_data;
         pt_nxt = 16'(cnt);
      end
   end

   // A report step completes on handshake or, if enabled, on consumer timeout.
   assign adv = (state == REPORT) && ((res_valid && res_ready) || to_hit);

`ifdef FILTER_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;

   assign to_hit = (state == REPORT) && !res_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Count stalled REPORT cycles; err stays set until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (state == REPORT && !res_ready) to_cnt <= to_cnt + 1'b1;
         else                               to_cnt <= '0;
         if (to_hit) err <= 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // Sweep sequencer with registered outputs; abort overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         step          <= '0;
         n_steps_q     <= '0;
         delay_step_q  <= '0;
         overlay_q     <= 1'b0;
         peak          <= '0;
         peak_time     <= '0;
         test_rate     <= 1'b0;
         test_overlay  <= 1'b0;
         test_delay    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         res_valid     <= 1'b0;
         res_step      <= '0;
         res_delay     <= '0;
         res_peak      <= '0;
         res_peak_time <= '0;
      end else begin
         test_rate <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start && n_steps != 8'd0) begin
                  delay_step_q <= delay_step;
                  n_steps_q    <= n_steps;
                  overlay_q    <= overlay_en;
                  test_overlay <= overlay_en;
                  test_delay   <= delay_start;
                  step         <= 8'd0;
                  cnt          <= '0;
                  busy         <= 1'b1;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == SET_LAST) begin
                  cnt       <= '0;
                  test_rate <= 1'b1;
                  state     <= WINDOW;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WINDOW: begin
               peak      <= pk_nxt;
               peak_time <= pt_nxt;
               if (cnt == WIN_LAST) begin
                  cnt           <= '0;
                  res_valid     <= 1'b1;
                  res_step      <= step;
                  res_delay     <= test_delay;
                  res_peak      <= pk_nxt;
                  res_peak_time <= pt_nxt;
                  state         <= REPORT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            REPORT: begin
               if (adv) begin
                  res_valid <= 1'b0;
                  step      <= step + 8'd1;
                  if (step + 8'd1 == n_steps_q) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     test_delay <= test_delay + delay_step_q;
                     state      <= SETTLE;
                  end
               end
            end
            FIN: begin
               busy         <= 1'b0;
               test_overlay <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (abort && state != IDLE) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_valid    <= 1'b0;
            test_rate    <= 1'b0;
            test_overlay <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_filter_test_sequencer.sv
// Bench for filter_test_sequencer: directed sweeps with a result scoreboard.
module tb_filter_test_sequencer;
   localparam int SETTLE = 4;
   localparam int WIN    = 100;
   localparam int TO     = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, abort = 1'b0, overlay_en = 1'b0, res_ready = 1'b0;
   logic [7:0] delay_start = '0, delay_step = '0, n_steps = '0;
   logic signed [15:0] filter_data;
   logic test_rate, test_overlay, busy, done, res_valid, err;
   logic [7:0] test_delay, res_step, res_delay;
   logic signed [15:0] res_peak;
   logic [15:0] res_peak_time;

   filter_test_sequencer #(
      .SETTLE_CYCLES(SETTLE), .WINDOW_CYCLES(WIN), .TIMEOUT_CYCLES(TO),
      .SIZE_DELAY(8), .SIZE_FILTER_DATA(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .delay_start(delay_start), .delay_step(delay_step), .n_steps(n_steps),
      .overlay_en(overlay_en), .filter_data(filter_data), .res_ready(res_ready),
      .test_rate(test_rate), .test_overlay(test_overlay), .test_delay(test_delay),
      .busy(busy), .done(done), .res_valid(res_valid), .res_step(res_step),
      .res_delay(res_delay), .res_peak(res_peak), .res_peak_time(res_peak_time),
      .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Generator response: waveform indexed by offset from the test_rate trigger.
   int prof = 0;
   int woff = 0;
   function automatic logic [15:0] prof_val(input int p, input int off);
      int v;
      case (p)
         1:       v = (off == 60) ? -1 : off - 30;
         2:       v = (off <= 37) ? 500 - (37 - off) * 10 : (off == 90) ? 500 : 300 - off;
         default: v = (off * 7) % 50 - 20;
      endcase
      return 16'(v);
   endfunction

   always @(posedge clk) woff <= test_rate ? 1 : woff + 1;
   assign filter_data = test_rate ? prof_val(prof, 0) : prof_val(prof, woff);

   task automatic model_peak(input int p, output logic [15:0] pk, output logic [15:0] pt);
      pk = prof_val(p, 0);
      pt = 16'd0;
      for (int o = 1; o < WIN; o++)
         if ($signed(prof_val(p, o)) > $signed(pk)) begin
            pk = prof_val(p, o);
            pt = 16'(o);
         end
   endtask

   typedef struct packed {
      logic [7:0]  s;
      logic [7:0]  d;
      logic [15:0] pk;
      logic [15:0] pt;
   } res_t;
   res_t sb[$];

   task automatic push_sweep(input int p, input int ds, input int st, input int n);
      logic [15:0] pk, pt;
      model_peak(p, pk, pt);
      for (int i = 0; i < n; i++) sb.push_back('{8'(i), 8'(ds + i * st), pk, pt});
   endtask

   // Monitor: event counters, hold-stability, and scoreboard pops on handshake.
   int n_done = 0, n_rate = 0, n_xfer = 0, n_valid = 0;
   res_t snap, e;
   logic hold = 1'b0;
   initial forever begin
      @(negedge clk);
      if (done) n_done++;
      if (test_rate) n_rate++;
      if (res_valid) n_valid++;
      if (res_valid && hold) begin
         chk("hold_step_delay", 32'({res_step, res_delay}), 32'({snap.s, snap.d}));
         chk("hold_peak", {res_peak, res_peak_time}, {snap.pk, snap.pt});
      end
      snap = '{res_step, res_delay, res_peak, res_peak_time};
      hold = res_valid && !res_ready;
      if (res_valid && res_ready) begin
         n_xfer++;
         if (sb.size() == 0) chk("sb_unexpected", 32'(1), 32'(0));
         else begin
            e = sb.pop_front();
            chk("res_step", 32'(res_step), 32'(e.s));
            chk("res_delay", 32'(res_delay), 32'(e.d));
            chk("res_peak", 32'(res_peak), 32'(e.pk));
            chk("res_peak_time", 32'(res_peak_time), 32'(e.pt));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go(input int ds, input int st, input int n, input logic ov);
      delay_start = 8'(ds);
      delay_step  = 8'(st);
      n_steps     = 8'(n);
      overlay_en  = ov;
      start       = 1'b1;
      tick(1);
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 3000) begin
         tick(1);
         k++;
      end
      chk({tag, "_done_seen"}, 32'(done), 32'(1));
      tick(1);
      chk({tag, "_busy_fall"}, 32'(busy), 32'(0));
      chk({tag, "_done_once"}, 32'(done), 32'(0));
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (!res_valid && k < 3000) begin
         tick(1);
         k++;
      end
      chk({tag, "_valid_seen"}, 32'(res_valid), 32'(1));
   endtask

   initial begin
      int r0, d0, x0, v0, seen, k;
      logic [15:0] pk, pt;

      // Reset state
      #3 reset = 1'b0;
      tick(2);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_test_rate", 32'(test_rate), 32'(0));
      chk("rst_overlay", 32'(test_overlay), 32'(0));
      chk("rst_test_delay", 32'(test_delay), 32'(0));
      chk("rst_res_peak", 32'(res_peak), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      reset = 1'b1;
      tick(5);

      // n_steps=0 start is ignored
      go(7, 1, 0, 1'b1);
      tick(3);
      chk("nsteps0_idle", 32'(busy), 32'(0));
      chk("nsteps0_no_rate", 32'(n_rate), 32'(0));

      // Basic sweep: 10, 15, 20; mixed-sign data with a -1 decoy
      prof = 1;
      push_sweep(1, 10, 5, 3);
      r0 = n_rate; d0 = n_done;
      res_ready = 1'b1;
      go(10, 5, 3, 1'b1);
      tick(2);
      chk("sweep_busy", 32'(busy), 32'(1));
      chk("sweep_overlay", 32'(test_overlay), 32'(1));
      go(99, 1, 1, 1'b0);  // start while busy is ignored
      tick(1);
      chk("sweep_overlay_latched", 32'(test_overlay), 32'(1));
      chk("sweep_delay0", 32'(test_delay), 32'(10));
      wait_done("sweep");
      chk("sweep_overlay_idle", 32'(test_overlay), 32'(0));
      chk("sweep_rates", 32'(n_rate - r0), 32'(3));
      chk("sweep_dones", 32'(n_done - d0), 32'(1));
      chk("sweep_sb_empty", 32'(sb.size()), 32'(0));

      // Peak: 500 at offset 37, tie at 90 keeps 37
      prof = 2;
      sb.push_back('{8'd0, 8'd0, 16'd500, 16'd37});
      go(0, 1, 1, 1'b0);
      wait_done("peak");
      chk("peak_sb_empty", 32'(sb.size()), 32'(0));

      // Backpressure: 20 stalled cycles, then exactly one transfer
      prof = 0;
      push_sweep(0, 3, 7, 2);
      res_ready = 1'b0;
      go(3, 7, 2, 1'b1);
      wait_valid("bp");
      x0 = n_xfer;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("bp_valid_held", 32'(res_valid), 32'(1));
      end
      chk("bp_no_xfer", 32'(n_xfer - x0), 32'(0));
      res_ready = 1'b1;
      tick(1);
      res_ready = 1'b0;
      tick(3);
      chk("bp_one_xfer", 32'(n_xfer - x0), 32'(1));
      chk("bp_valid_drop", 32'(res_valid), 32'(0));
      res_ready = 1'b1;
      wait_done("bp");
      chk("bp_sb_empty", 32'(sb.size()), 32'(0));

      // Wrap: 250 then (250+10) mod 256 = 4
      model_peak(0, pk, pt);
      sb.push_back('{8'd0, 8'd250, pk, pt});
      sb.push_back('{8'd1, 8'd4, pk, pt});
      go(250, 10, 2, 1'b0);
      wait_done("wrap");
      chk("wrap_sb_empty", 32'(sb.size()), 32'(0));

      // Abort inside the step-1 window
      prof = 1;
      push_sweep(1, 20, 3, 1);
      go(20, 3, 3, 1'b1);
      seen = 0; k = 0;
      while (seen < 2 && k < 2000) begin
         tick(1);
         if (test_rate) seen++;
         k++;
      end
      chk("abort_window_reached", 32'(seen), 32'(2));
      tick(10);
      d0 = n_done;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_overlay", 32'(test_overlay), 32'(0));
      chk("abort_rate", 32'(test_rate), 32'(0));
      chk("abort_valid", 32'(res_valid), 32'(0));
      v0 = n_valid;
      tick(300);
      chk("abort_no_valid", 32'(n_valid - v0), 32'(0));
      chk("abort_no_done", 32'(n_done - d0), 32'(0));
      chk("abort_sb_empty", 32'(sb.size()), 32'(0));

`ifdef FILTER_SEQ_TIMEOUT_EN
      // Timeout: stalled consumer, err after 16 REPORT cycles, sweep completes
      prof = 0;
      res_ready = 1'b0;
      go(1, 1, 2, 1'b0);
      wait_valid("to");
      tick(15);
      chk("to_err_before", 32'(err), 32'(0));
      chk("to_valid_before", 32'(res_valid), 32'(1));
      tick(1);
      chk("to_err_set", 32'(err), 32'(1));
      chk("to_valid_drop", 32'(res_valid), 32'(0));
      wait_done("to");
      chk("to_err_sticky", 32'(err), 32'(1));
`else
      // No timeout: REPORT waits indefinitely, err stays low
      prof = 0;
      res_ready = 1'b0;
      go(1, 1, 2, 1'b0);
      wait_valid("nto");
      tick(40);
      chk("nto_valid_held", 32'(res_valid), 32'(1));
      chk("nto_err_low", 32'(err), 32'(0));
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("nto_abort_idle", 32'(busy), 32'(0));
`endif

      // Reset mid-sweep discards it without done
      res_ready = 1'b1;
      go(5, 1, 2, 1'b1);
      tick(3);
      d0 = n_done; v0 = n_valid;
      #2 reset = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy), 32'(0));
      chk("mrst_overlay", 32'(test_overlay), 32'(0));
      chk("mrst_err", 32'(err), 32'(0));
      tick(2);
      reset = 1'b1;
      tick(300);
      chk("mrst_no_done", 32'(n_done - d0), 32'(0));
      chk("mrst_no_valid", 32'(n_valid - v0), 32'(0));
      chk("mrst_idle", 32'(busy), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/filter_test_sequencer.md
FILTER_TEST_SEQUENCER -- requirements
Module: filter_test_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64: idle cycles before each measurement window.
REQ-002 Parameter WINDOW_CYCLES, default 256: measurement window length in cycles.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: report-handshake timeout, used only under FILTER_SEQ_TIMEOUT_EN.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin a sweep, sampled in IDLE only.
- abort  in  1  cancel the sweep.
- delay_start  in  SIZE_DELAY  first test_delay value.
- delay_step  in  SIZE_DELAY  delay increment per step.
- n_steps  in  8  number of measurement steps.
- overlay_en  in  1  value driven on test_overlay during a sweep.
- filter_data  in  SIZE_FILTER_DATA  signed filter output under test.
- res_ready  in  1  result consumer ready.
- test_rate  out  1  one-cycle trigger pulse to the signal generator.
- test_overlay  out  1  overlay control to the generator.
- test_delay  out  SIZE_DELAY  delay control to the generator.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse marking sweep completion.
- res_valid  out  1  result valid.
- res_step  out  8  index of the step being reported.
- res_delay  out  SIZE_DELAY  test_delay in force for that step.
- res_peak  out  SIZE_FILTER_DATA  signed maximum of filter_data over the window.
- res_peak_time  out  16  cycle offset of the peak within the window.
- err  out  1  sticky timeout flag.

Function
REQ-005 The FSM SHALL have the states IDLE, SETTLE, WINDOW, REPORT and FIN.
REQ-006 In IDLE, start=1 with n_steps≠0 SHALL:
- latch delay_step, n_steps and overlay_en;
- load test_delay=delay_start and step=0;
- go to SETTLE on the next cycle.
REQ-007 In IDLE, start=1 with n_steps=0 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to WINDOW.
REQ-009 test_rate SHALL be 1 for exactly the first cycle of WINDOW and 0 at all other times.
REQ-010 WINDOW SHALL last exactly WINDOW_CYCLES cycles; on the first WINDOW cycle, peak SHALL load filter_data and peak_time SHALL load 0.
REQ-011 On later WINDOW cycles, peak and peak_time SHALL update only when filter_data > peak (signed compare), so ties keep the earliest offset.
REQ-012 After the last WINDOW cycle the FSM SHALL go to REPORT.
REQ-013 In REPORT:
- res_valid=1;
- res_step, res_delay, res_peak and res_peak_time SHALL be held stable until a cycle with res_valid and res_ready both high.
REQ-014 On the handshake, step SHALL increment. If step+1==n_steps the FSM SHALL go to FIN. Otherwise test_delay SHALL become test_delay+delay_step (modulo 2^SIZE_DELAY) and the FSM SHALL go to SETTLE.
REQ-015 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-016 test_overlay SHALL equal the latched overlay_en while busy and 0 in IDLE.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, with res_valid=0, test_rate=0, test_overlay=0 and no done pulse.
REQ-018 If abort and the REPORT handshake occur in the same cycle, abort SHALL win, and the result SHALL count as delivered.
REQ-019 start SHALL be ignored while busy.
REQ-020 The res_* outputs SHALL be registered, with zero combinational path from inputs.

Reset
REQ-021 reset=0 SHALL asynchronously force:
- state=IDLE;
- all outputs to 0, including err;
- step, peak and the counters to 0.
REQ-022 Assertion of reset mid-sweep SHALL discard the sweep without a done pulse.
REQ-023 Deassertion of reset SHALL be synchronised to clk.

Configuration
REQ-024 With macro FILTER_SEQ_TIMEOUT_EN defined, REPORT SHALL count cycles with res_ready=0. On reaching TIMEOUT_CYCLES it SHALL drop the result, set err=1 (sticky until reset) and proceed as if the handshake had occurred.
REQ-025 Without FILTER_SEQ_TIMEOUT_EN, REPORT SHALL wait indefinitely, err SHALL be tied to 0, and no timeout counter logic SHALL exist.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Sweep: delay_start=10, delay_step=5, n_steps=3, res_ready=1 -> results with res_delay 10, 15, 20 and res_step 0, 1, 2; then done pulses once; busy falls next cycle.
- Peak: filter_data ramp peaking at 500 on window offset 37, then repeating 500 at offset 90 -> res_peak=500, res_peak_time=37.
- Backpressure: res_ready held 0 for 20 cycles -> res_valid held and res_* stable throughout; exactly one result transferred on release.
- Wrap: SIZE_DELAY=8, delay_start=250, delay_step=10, n_steps=2 -> res_delay 250 then 4.
- Abort: abort during WINDOW of step 1 -> IDLE next cycle, no done pulse, no further res_valid.
- Timeout (FILTER_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): res_ready=0 -> err=1 after 16 REPORT cycles and the sweep continues to done.
